// File: rtl/router_pkg.sv
// Shared types and default sizing for the router output-port slice.
package router_pkg;

  // Packet-level arbitration state of an output port.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_IN  = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CREDITS = 4;

endpackage

// File: rtl/router_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NUM_IN.
module router_rr_pick
  import router_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  index,
  output logic              any
);

  int cand;

  // Scan requesters starting at ptr; the first hit becomes the one-hot grant.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = (int'(ptr) + k) % NUM_IN;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        index       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/router_out_port_arbiter.sv
// Wormhole output-port controller: round-robin packet arbitration, head-to-tail
// lock, credit-gated transfers and registered output flops.
module router_out_port_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CREDITS = DEF_CREDITS,
  localparam int CNT_W  = $clog2(CREDITS + 1),
  localparam int IDX_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN-1:0]        in_tail,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic                     out_tail,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     credit_return,
  output logic [CNT_W-1:0]         credit_count,
  output logic                     credit_ovf
);

  arb_state_e        state, state_next;
  logic [IDX_W-1:0]  owner, owner_next;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_next;
  logic [NUM_IN-1:0] pick_grant;
  logic [IDX_W-1:0]  pick_index;
  logic              pick_any;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_tail;
  logic [DATA_W-1:0] sel_data;
  logic              credit_ok;
  logic              xfer;
  logic [DATA_W-1:0] lane [NUM_IN];

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_IN - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    assign lane[g] = in_data[g*DATA_W +: DATA_W];
  end

  router_rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_index),
    .any   (pick_any)
  );

  assign credit_ok = (credit_count != '0);
  assign sel_idx   = (state == IDLE) ? pick_index : owner;
  assign sel_tail  = in_tail[sel_idx];
  assign sel_data  = lane[sel_idx];
  assign xfer      = |(in_valid & in_ready);

  // Ready goes to the round-robin winner when idle, or to the lock owner even when it bubbles.
  always_comb begin
    in_ready = '0;
    if (!reset && credit_ok) begin
      if (state == IDLE) begin
        in_ready = pick_any ? pick_grant : '0;
      end else begin
        in_ready[owner] = 1'b1;
      end
    end
  end

  // Next-state: head flit locks the port, tail flit releases it and advances the pointer.
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (sel_tail) begin
            rr_ptr_next = next_idx(pick_index);
          end else begin
            state_next = LOCKED;
            owner_next = pick_index;
          end
        end
      end
      LOCKED: begin
        if (xfer && sel_tail) begin
          state_next  = IDLE;
          rr_ptr_next = next_idx(owner);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Credit counter: consume on transfer, replenish on return, saturate and flag overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_count <= CNT_W'(CREDITS);
      credit_ovf   <= 1'b0;
    end else begin
      if (xfer && !credit_return) begin
        credit_count <= credit_count - CNT_W'(1);
      end else if (!xfer && credit_return) begin
        if (credit_count == CNT_W'(CREDITS)) begin
          credit_ovf <= 1'b1;
        end else begin
          credit_count <= credit_count + CNT_W'(1);
        end
      end
    end
  end

  // Output flops: one valid pulse per accepted flit, payload and tail hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_tail  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= xfer;
      if (xfer) begin
        out_tail <= sel_tail;
        out_data <= sel_data;
      end
    end
  end

endmodule
